// File: rtl/serial_bus_arbiter_if.sv
// Serial bus arbitration interface: request/done from the masters' side,
// grant/status back from the arbiter.
interface serial_bus_arbiter_if #(
  parameter int MASTERS = 2,
  parameter int MID_W   = $clog2(MASTERS)
);
  logic [MASTERS-1:0] req;
  logic               bus_done;
  logic [MASTERS-1:0] grant;
  logic [MID_W-1:0]   grant_id;
  logic               bus_busy;
  logic               timeout;

  // Requesting side: drives requests and the completion pulse.
  modport master (
    output req,
    output bus_done,
    input  grant,
    input  grant_id,
    input  bus_busy,
    input  timeout
  );

  // Arbiter side: samples requests, drives the grant.
  modport slave (
    input  req,
    input  bus_done,
    output grant,
    output grant_id,
    output bus_busy,
    output timeout
  );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for a shared serial bus. One grant at a time, one
// turnaround cycle after every grant, and a hold counter that forcibly ends
// grants lasting MAX_HOLD cycles.
module serial_bus_arbiter #(
  parameter int MASTERS  = 2,
  parameter int MAX_HOLD = 256,
  parameter int MID_W    = $clog2(MASTERS)
) (
  input logic                 clk,
  input logic                 resetn,
  serial_bus_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [MID_W-1:0] ptr_q, ptr_d;
  logic [MID_W-1:0] winner_q, winner_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;

  logic [MID_W-1:0] rr_pick;
  logic [MID_W-1:0] rr_cand;
  logic             rr_found;
  logic             grant_end;

  // Index increment that wraps at MASTERS (MASTERS need not be a power of 2).
  function automatic logic [MID_W-1:0] wrap_inc(input logic [MID_W-1:0] v);
    return (v == MID_W'(MASTERS - 1)) ? '0 : v + 1'b1;
  endfunction

  // Round-robin search: first set request at or after ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_cand  = ptr_q;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (!rr_found && bus.req[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
      rr_cand = wrap_inc(rr_cand);
    end
  end

  // Any of completion, request drop or hold limit ends the grant.
  always_comb begin
    grant_end = bus.bus_done || !bus.req[winner_q] ||
                (hold_q == CNT_W'(MAX_HOLD - 1));
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d  = GRANT;
          winner_d = rr_pick;
          hold_d   = '0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          state_d = RELEASE;
          // Completion or request drop at the limit wins over the timeout.
          timeout_d = !bus.bus_done && bus.req[winner_q];
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        ptr_d   = wrap_inc(winner_q);
        hold_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      winner_q  <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Grant decodes straight from state so reset removes it immediately.
  always_comb begin
    bus.grant    = (state_q == GRANT) ? (MASTERS'(1) << winner_q) : '0;
    bus.grant_id = winner_q;
    bus.bus_busy = (state_q == GRANT);
    bus.timeout  = timeout_q;
  end

endmodule

// File: doc/serial_bus_arbiter.md
SERIAL_BUS_ARBITER -- requirements
Module: serial_bus_arbiter

Interface
REQ-001 Parameter MASTERS, default 2, number of requesting masters sharing the serial bus (2..8).
REQ-002 Parameter MAX_HOLD, default 256, maximum cycles one grant may last before forced release (>=4).
REQ-003 Parameter MID_W, default $clog2(MASTERS), width of grant_id.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 req  input  MASTERS  per-master bus request; a master holds its bit high for the whole transaction.
REQ-007 bus_done  input  1  one-cycle pulse from the bus side when the current transaction completes (last word accepted).
REQ-008 grant  output  MASTERS  one-hot (or zero) bus grant; drives the interconnect mux select.
REQ-009 grant_id  output  MID_W  binary index of the granted master; holds its last value when grant is zero.
REQ-010 bus_busy  output  1  high exactly while grant is non-zero.
REQ-011 timeout  output  1  one-cycle pulse when a grant is forcibly ended by the hold counter.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, GRANT, RELEASE.
REQ-013 IDLE: grant=0; if req!=0 at a rising edge, SHALL select a winner and enter GRANT, with grant one-hot on the winner from the next cycle (1-cycle latency req->grant).
REQ-014 Winner selection SHALL be round-robin: search starts at index ptr and wraps modulo MASTERS; the first set req bit wins.
REQ-015 IDLE with req==0 SHALL remain in IDLE with ptr unchanged.
REQ-016 GRANT: grant and grant_id SHALL stay constant; hold counter increments by 1 each cycle starting at 0 on entry.
REQ-017 GRANT SHALL exit to RELEASE on the first edge where any of: bus_done=1, req[winner]=0, or hold counter == MAX_HOLD-1.
REQ-018 Exit on hold counter limit with bus_done=0 and req[winner]=1 SHALL pulse timeout for the first RELEASE cycle; bus_done or req drop in the same cycle as the limit SHALL take priority (no timeout).
REQ-019 RELEASE: grant=0 for exactly one turnaround cycle; ptr SHALL be set to (winner+1) mod MASTERS; next state IDLE.
REQ-020 Minimum gap between two consecutive grants SHALL be 2 cycles of grant=0 (RELEASE + IDLE arbitration).
REQ-021 Requests changing while in GRANT or RELEASE SHALL not affect the current grant.
REQ-022 A master still holding req after its own release SHALL be served again only after all other requesting masters (round-robin fairness).
REQ-023 Hold counter SHALL be $clog2(MAX_HOLD) bits wide and SHALL never wrap while in GRANT.
REQ-024 grant SHALL never have more than one bit set; bus_busy SHALL equal |grant.
REQ-025 bus_done while in IDLE or RELEASE SHALL be ignored.

Reset
REQ-026 resetn low SHALL immediately (asynchronously) force state=IDLE, grant=0, bus_busy=0, timeout=0, grant_id=0, ptr=0, hold counter=0.
REQ-027 Reset asserted mid-GRANT SHALL drop grant without passing through RELEASE; after release of reset, arbitration restarts from ptr=0.
REQ-028 First arbitration decision SHALL occur on the first rising edge with resetn high and req!=0.

Verification
REQ-029 Single request: MASTERS=2, req=01 at cycle 0 -> grant=01, grant_id=0, bus_busy=1 at cycle 1; bus_done pulse at cycle 5 -> grant=00 at cycle 6, ptr=1.
REQ-030 Contention: req=11 held continuously, bus_done every 4th grant cycle -> grants alternate 01,10,01,10 with 2 idle cycles between each.
REQ-031 Timeout: MAX_HOLD=8, req=01 held, no bus_done -> grant high for exactly 8 cycles, timeout pulses once, then grant=00; with req still 01, grant=01 again 2 cycles later.
REQ-032 Req drop: grant on master 1, req[1] falls at cycle k -> grant=00 at k+1, no timeout pulse.
REQ-033 Reset mid-grant: MASTERS=4, grant=0100, resetn low asynchronously -> grant=0000 same cycle; after reset with req=1100 -> grant=0100 (ptr=0 search) one cycle after first edge.
REQ-034 Priority at limit: bus_done asserted on cycle where hold counter == MAX_HOLD-1 -> normal release, timeout stays 0.
